// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, bank occupancy states and the
// 5-bit index reversal used to place time-ordered samples into lanes.
package fft_pkg;
  localparam int c_FFT_POINTS = 32;
  localparam int c_FFT_LOG2   = 5;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  function automatic logic [c_FFT_LOG2-1:0] bitrev5(input logic [c_FFT_LOG2-1:0] i_idx);
    bitrev5 = {i_idx[0], i_idx[1], i_idx[2], i_idx[3], i_idx[4]};
  endfunction
endpackage

// File: rtl/fft_pingpong_bank.sv
// One 32 x p_width sample bank of the loader's ping-pong pair.
// Ports:
//   CLK      clock
//   i_wrEn   write strobe
//   i_lane   destination lane (already bit-reversed by the caller)
//   i_data   sample to store
//   o_frame  whole bank, lane k at bits [k*p_width +: p_width]
// Storage has no reset: the top masks the frame while it is not valid.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int p_width = 8
) (
  input  logic                            CLK,
  input  logic                            i_wrEn,
  input  logic [c_FFT_LOG2-1:0]           i_lane,
  input  logic [p_width-1:0]              i_data,
  output logic [c_FFT_POINTS*p_width-1:0] o_frame
);
  logic [c_FFT_POINTS-1:0][p_width-1:0] r_mem;

  always_ff @(posedge CLK) begin
    if (i_wrEn) r_mem[i_lane] <= i_data;
  end

  assign o_frame = r_mem;
endmodule

// File: rtl/fft_input_bitrev_loader.sv
// Serial-to-parallel front end of the 32-point FFT. Samples arrive one per
// handshake in time order and are written to lane bitrev5(n), so stage 0 can
// take adjacent lane pairs. Two banks ping-pong: one fills while the other is
// held for the datapath.
// Ports:
//   CLK            clock, rising edge
//   RST            asynchronous active-low reset
//   i_valid        sample valid
//   i_data         signed sample
//   o_ready        a sample can be taken this cycle
//   o_frameValid   o_frame holds a complete frame (registered)
//   i_frameAccept  downstream takes the frame this cycle
//   o_frame        32 lanes, lane k at [k*W +: W]; zero while not valid
//   o_overflow     (only with LOADER_OVERFLOW_EN) sticky dropped-sample flag
// Optional feature macro: LOADER_OVERFLOW_EN.
module fft_input_bitrev_loader
  import fft_pkg::*;
#(
  parameter int p_inputWidth = 8,
  parameter int p_points     = 32
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 i_valid,
  input  logic [p_inputWidth-1:0]              i_data,
  output logic                                 o_ready,
  output logic                                 o_frameValid,
  input  logic                                 i_frameAccept,
  output logic [c_FFT_POINTS*p_inputWidth-1:0] o_frame
`ifdef LOADER_OVERFLOW_EN
  ,
  output logic                                 o_overflow
`endif
);
  localparam int c_FW = c_FFT_POINTS * p_inputWidth;

  if (p_points != c_FFT_POINTS) begin : g_badPoints
    $error("fft_input_bitrev_loader: only p_points=32 is supported");
  end

  bank_state_t [1:0]          r_bankState;
  bank_state_t [1:0]          w_nextState;
  logic [c_FFT_LOG2-1:0]      r_wrPtr;
  logic                       r_wrBank;
  logic                       r_rdBank;
  logic                       r_frameValid;
  logic                       w_wrEn;
  logic                       w_accept;
  logic                       w_lastWrite;
  logic                       w_nextRdBank;
  logic [1:0][c_FW-1:0]       w_bankFrame;

  assign o_ready     = (r_bankState[r_wrBank] != FULL);
  assign w_wrEn      = i_valid & o_ready;
  assign w_accept    = r_frameValid & i_frameAccept;
  assign w_lastWrite = (r_wrPtr == 5'(c_FFT_POINTS - 1));

  // Write and accept always target different banks (accept needs rdBank FULL,
  // write needs wrBank not FULL), so applying both in order is safe.
  always_comb begin
    w_nextState = r_bankState;
    if (w_accept) w_nextState[r_rdBank] = EMPTY;
    if (w_wrEn)   w_nextState[r_wrBank] = w_lastWrite ? FULL : FILLING;
    w_nextRdBank = r_rdBank ^ w_accept;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bankState  <= {EMPTY, EMPTY};
      r_wrPtr      <= '0;
      r_wrBank     <= 1'b0;
      r_rdBank     <= 1'b0;
      r_frameValid <= 1'b0;
    end else begin
      r_bankState <= w_nextState;
      r_rdBank    <= w_nextRdBank;
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 5'd1;
        if (w_lastWrite) r_wrBank <= ~r_wrBank;
      end
      // Look ahead at next state so valid rises right after the 32nd write
      // and stays up when a new frame completes as the old one is accepted.
      r_frameValid <= (w_nextState[w_nextRdBank] == FULL);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_pingpong_bank #(.p_width(p_inputWidth)) u_bank (
      .CLK     (CLK),
      .i_wrEn  (w_wrEn & (r_wrBank == 1'(g))),
      .i_lane  (bitrev5(r_wrPtr)),
      .i_data  (i_data),
      .o_frame (w_bankFrame[g])
    );
  end

  assign o_frameValid = r_frameValid;
  assign o_frame      = r_frameValid ? w_bankFrame[r_rdBank] : '0;

`ifdef LOADER_OVERFLOW_EN
  logic r_overflow;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     r_overflow <= 1'b0;
    else if (i_valid && !o_ready) r_overflow <= 1'b1;
  end
  assign o_overflow = r_overflow;
`endif
endmodule

// File: tb/tb_fft_input_bitrev_loader.sv
module tb_fft_input_bitrev_loader;
  localparam int W  = 8;
  localparam int FW = 32 * W;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          i_valid = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          o_ready;
  logic          o_frameValid;
  logic          i_frameAccept = 1'b0;
  logic [FW-1:0] o_frame;
`ifdef LOADER_OVERFLOW_EN
  logic          o_overflow;
`endif

  fft_input_bitrev_loader #(.p_inputWidth(W), .p_points(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_ready       (o_ready),
    .o_frameValid  (o_frameValid),
    .i_frameAccept (i_frameAccept),
    .o_frame       (o_frame)
`ifdef LOADER_OVERFLOW_EN
    ,
    .o_overflow    (o_overflow)
`endif
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // reference model: time-ordered samples -> bit-reversed frame
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur_f = '0;
  int            mdl_n = 0;

  function automatic logic [4:0] rev(input int n);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) r[b] = n[4-b];
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input bit acc, input bit chk_rdy);
    i_valid = 1'b1;
    i_data  = d;
    if (chk_rdy) chk("ready_stream", o_ready, 1'b1);
    if (acc) begin
      cur_f[rev(mdl_n)*W +: W] = d;
      mdl_n++;
      if (mdl_n == 32) begin
        exp_q.push_back(cur_f);
        mdl_n = 0;
      end
    end
    @(posedge CLK); #1;
    i_valid = 1'b0;
  endtask

  task automatic accept_pulse(input int n);
    i_frameAccept = 1'b1;
    repeat (n) begin @(posedge CLK); #1; end
    i_frameAccept = 1'b0;
  endtask

  task automatic do_reset;
    RST = 1'b0; i_valid = 1'b0; i_frameAccept = 1'b0;
    @(negedge CLK);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_frameValid, 1'b0);
    chk("rst_frame", o_frame, '0);
    @(posedge CLK); #1;
    RST = 1'b1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    mdl_n = 0;
    cur_f = '0;
  endtask

  // monitor: every frame transfer is compared against the scoreboard
  int cyc = 0;
  int last_pop = -1;
  int pops = 0;
  bit chk_period = 1'b0;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (RST && o_frameValid && i_frameAccept) begin
      if (exp_q.size() == 0) chk("unexpected_frame", 1'b1, 1'b0);
      else chk("frame", o_frame, exp_q.pop_front());
      if (chk_period && last_pop >= 0) chk("frame_period", cyc - last_pop, 32);
      last_pop = cyc;
      pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: ramp frame, lane placement and valid latency
    do_reset();
    for (int n = 0; n < 31; n++) send(W'(n), 1'b1, 1'b0);
    @(negedge CLK);
    chk("s1_valid_before", o_frameValid, 1'b0);
    send(W'(31), 1'b1, 1'b0);
    @(negedge CLK);
    chk("s1_valid_after", o_frameValid, 1'b1);
    chk("s1_lane0", o_frame[0*W +: W], 8'd0);
    chk("s1_lane1", o_frame[1*W +: W], 8'd16);
    chk("s1_lane2", o_frame[2*W +: W], 8'd8);
    chk("s1_lane3", o_frame[3*W +: W], 8'd24);
    chk("s1_lane31", o_frame[31*W +: W], 8'd31);
    chk("s1_hold", o_frameValid, 1'b1);
    accept_pulse(1);
    @(negedge CLK);
    chk("s1_valid_cleared", o_frameValid, 1'b0);
    chk("s1_frame_zero", o_frame, '0);

    // 2: fill both banks, drop one sample, drain two frames
    do_reset();
    for (int i = 0; i < 64; i++) send(W'(i * 3 + 1), 1'b1, 1'b0);
    @(negedge CLK);
    chk("s2_ready_low", o_ready, 1'b0);
    chk("s2_valid", o_frameValid, 1'b1);
`ifdef LOADER_OVERFLOW_EN
    chk("s2_ovf_before", o_overflow, 1'b0);
`endif
    send(8'h7F, 1'b0, 1'b0);
`ifdef LOADER_OVERFLOW_EN
    @(negedge CLK);
    chk("s2_ovf_set", o_overflow, 1'b1);
`endif
    accept_pulse(2);
    @(negedge CLK);
    chk("s2_valid_drained", o_frameValid, 1'b0);
    chk("s2_ready_back", o_ready, 1'b1);
`ifdef LOADER_OVERFLOW_EN
    chk("s2_ovf_sticky", o_overflow, 1'b1);
    RST = 1'b0;
    #1;
    chk("s2_ovf_reset", o_overflow, 1'b0);
`endif

    // 3a: continuous stream with accept held high
    do_reset();
    pops = 0; last_pop = -1; chk_period = 1'b1;
    i_frameAccept = 1'b1;
    for (int i = 0; i < 96; i++) send(W'($urandom_range(0, 255)), 1'b1, 1'b1);
    repeat (3) begin @(posedge CLK); #1; end
    i_frameAccept = 1'b0;
    chk_period = 1'b0;
    chk("s3_frames", pops, 3);

    // 3b: 32nd write of new frame coincides with accept of held frame
    do_reset();
    for (int i = 0; i < 63; i++) send(W'($urandom_range(0, 255)), 1'b1, 1'b0);
    i_frameAccept = 1'b1;
    send(W'($urandom_range(0, 255)), 1'b1, 1'b0);
    @(negedge CLK);
    chk("s3_no_gap", o_frameValid, 1'b1);
    @(posedge CLK); #1;
    i_frameAccept = 1'b0;
    @(negedge CLK);
    chk("s3_drained", o_frameValid, 1'b0);

    // 4: reset mid-frame discards partial data
    do_reset();
    for (int i = 0; i < 10; i++) send(W'(i + 40), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++) send(8'hFF, 1'b1, 1'b0);
    @(negedge CLK);
    chk("s4_all_ones", o_frame, {FW{1'b1}});
    accept_pulse(1);

    // 5: signed extremes, even n -> lanes 0..15, odd n -> lanes 16..31
    do_reset();
    for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 8'h80 : 8'h7F, 1'b1, 1'b0);
    @(negedge CLK);
    chk("s5_extremes", o_frame, {{16{8'h7F}}, {16{8'h80}}});
    accept_pulse(1);

    repeat (3) @(posedge CLK);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
